// File: rtl/popcount_pkg.sv
// Shared types and constants for the 22-input popcount family and its
// unary (thermometer) transmitter.
package popcount_pkg;

  localparam int N_POP  = 22;
  localparam int CW_POP = 5;

  typedef logic [CW_POP-1:0] pop_cnt_t;
  typedef logic [N_POP-1:0]  pop_vec_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } tx_state_e;

endpackage

// File: rtl/popcount_thermo_enc.sv
// Combinational count -> thermometer encoder with clamp to N and saturation
// flag. Bit 0 fills first.
module popcount_thermo_enc
  import popcount_pkg::*;
#(
  parameter int N  = N_POP,
  parameter int CW = CW_POP
) (
  input  logic [CW-1:0] count,
  output logic [N-1:0]  vec,
  output logic [CW-1:0] cnt_clamped,
  output logic          sat
);

  localparam logic [CW-1:0] N_C = CW'(N);

  always_comb begin
    sat         = (count > N_C);
    cnt_clamped = sat ? N_C : count;
    vec         = '0;
    for (int i = 0; i < N; i++) begin
      vec[i] = (i < int'(cnt_clamped));
    end
  end

endmodule

// File: rtl/popcount_unary_tx.sv
// Binary count in, serial unary stream plus thermometer vector out.
// Optional self-check (sticky err) is built when POPCOUNT_TX_CHECK_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for a count, in_ready=1, no beats
//   STREAM | emitting beats 0..N-1 of the latched count
module popcount_unary_tx
  import popcount_pkg::*;
#(
  parameter int N  = N_POP,
  parameter int CW = CW_POP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic [N-1:0]  out_vec,
  output logic          sat,
  output logic          err
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  vec_q, vec_d;
  logic          sat_q, sat_d;

  logic [N-1:0]  enc_vec;
  logic [CW-1:0] enc_cnt;
  logic          enc_sat;
  logic          accept;
  logic          beat_hs;
  logic          at_last;

  popcount_thermo_enc #(.N(N), .CW(CW)) u_enc (
    .count       (in_count),
    .vec         (enc_vec),
    .cnt_clamped (enc_cnt),
    .sat         (enc_sat)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    sat_d     = sat_q;
    at_last   = (beat_q == LAST);
    out_valid = (state_q == STREAM);
    out_bit   = out_valid && (beat_q < cnt_q);
    out_last  = out_valid && at_last;
    // Accepting on the final handshake gives zero-bubble back-to-back streams.
    in_ready  = (state_q == IDLE) || (out_ready && at_last);
    accept    = in_valid && in_ready;
    beat_hs   = out_valid && out_ready;

    if (beat_hs) begin
      if (!at_last) beat_d = beat_q + 1'b1;
      else          state_d = IDLE;
    end
    if (accept) begin
      state_d = STREAM;
      beat_d  = '0;
      cnt_d   = enc_cnt;
      vec_d   = enc_vec;
      sat_d   = enc_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      sat_q   <= sat_d;
    end
  end

  assign out_vec = vec_q;
  assign sat     = sat_q;

`ifdef POPCOUNT_TX_CHECK_EN
  logic [CW-1:0] ones_q, ones_d;
  logic [CW-1:0] vec_ones;
  logic          err_q, err_d;
  logic          chk_q, chk_d;

  always_comb begin
    vec_ones = '0;
    for (int i = 0; i < N; i++) begin
      vec_ones = vec_ones + CW'(vec_q[i]);
    end
    ones_d = ones_q;
    err_d  = err_q;
    chk_d  = accept;
    if (beat_hs && out_bit) ones_d = ones_q + 1'b1;
    if (beat_hs && out_last && ((ones_q + CW'(out_bit)) != cnt_q)) err_d = 1'b1;
    // Vector is checked the cycle after it is latched.
    if (chk_q && (vec_ones != cnt_q)) err_d = 1'b1;
    if (accept) ones_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      err_q  <= 1'b0;
      chk_q  <= 1'b0;
    end else begin
      ones_q <= ones_d;
      err_q  <= err_d;
      chk_q  <= chk_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
